// File: rtl/mem_burst_unloader_pkg.sv
// mem_burst_unloader_pkg: readback state encoding and slice width helper
package mem_burst_unloader_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, STREAM = 3'd3, DONE = 3'd4} state_t;
    function automatic int slice_width(input int no_of_digits, input int radix_bits);
        return (no_of_digits + 1) * radix_bits;
    endfunction
endpackage

// File: rtl/mem_burst_unloader_if.sv
// mem_burst_unloader_if: RAM read port plus valid/ready slice stream
interface mem_burst_unloader_if
    import mem_burst_unloader_pkg::*;
#(
    parameter int W = slice_width(8, 3),
    parameter int address_width = 14,
    parameter int burst_index = 8
);
    logic [address_width-1:0] rd_addr;
    logic [W*burst_index-1:0] ram_q;
    logic [W-1:0] dout;
    logic dout_valid;
    logic dout_ready;
    modport master(output rd_addr, dout, dout_valid, input ram_q, dout_ready);
    modport slave(input rd_addr, dout, dout_valid, output ram_q, dout_ready);
endinterface

// File: rtl/mem_burst_unloader_burst_slice_mux.sv
// burst_slice_mux: picks one W-bit slice out of a burst word
module burst_slice_mux #(
    parameter int W = 27,
    parameter int burst_index = 8,
    parameter int sel_width = 3
) (
    input  logic [W*burst_index-1:0] data,
    input  logic [sel_width-1:0]     sel,
    output logic [W-1:0]             slice
);
    always_comb begin
        slice = '0;
        for (int k = 0; k < burst_index; k++)
            if (sel == sel_width'(k)) slice = data[k*W +: W];
    end
endmodule

// File: rtl/mem_burst_unloader.sv
// mem_burst_unloader: streams every RAM word out as slices; optional MEM_UNLOAD_CHECKSUM_EN adds an XOR checksum
module mem_burst_unloader
    import mem_burst_unloader_pkg::*;
#(
    parameter int no_of_digits = 8,
    parameter int radix_bits = 3,
    parameter int address_width = 14,
    parameter int max_ram_address = 1024,
    parameter int burst_index = 8,
    parameter int ram_latency = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start_signal,
    mem_burst_unloader_if.master bus,
    output logic busy,
    output logic transfer_done
`ifdef MEM_UNLOAD_CHECKSUM_EN
    ,
    output logic [slice_width(no_of_digits, radix_bits)-1:0] checksum
`endif
);
    localparam int W = slice_width(no_of_digits, radix_bits);
    localparam int sel_width = burst_index > 1 ? $clog2(burst_index) : 1;
    localparam logic [sel_width-1:0] last_slice = sel_width'(burst_index - 1);
    localparam logic [address_width-1:0] last_addr = address_width'(max_ram_address - 1);

    state_t state;
    logic [1:0] lat;
    logic [sel_width-1:0] slice_idx, sel;
    logic [W*burst_index-1:0] buffer, mux_data;
    logic [W-1:0] next_slice;
    logic xfer;

    // LOAD presents slice 0 straight from ram_q so streaming starts without a bubble
    assign mux_data = state == LOAD ? bus.ram_q : buffer;
    assign sel = state == LOAD ? '0 : slice_idx + 1'b1;
    assign xfer = bus.dout_valid & bus.dout_ready;

    burst_slice_mux #(.W(W), .burst_index(burst_index), .sel_width(sel_width)) u_mux (
        .data(mux_data),
        .sel(sel),
        .slice(next_slice)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lat <= '0;
            slice_idx <= '0;
            buffer <= '0;
            bus.rd_addr <= '0;
            bus.dout <= '0;
            bus.dout_valid <= 1'b0;
            busy <= 1'b0;
            transfer_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_signal) begin
                    state <= FETCH;
                    lat <= 2'(ram_latency);
                    busy <= 1'b1;
                end
                FETCH: begin
                    lat <= lat - 1'b1;
                    if (lat == 2'd1) state <= LOAD;
                end
                LOAD: begin
                    buffer <= bus.ram_q;
                    slice_idx <= '0;
                    bus.dout <= next_slice;
                    bus.dout_valid <= 1'b1;
                    state <= STREAM;
                end
                STREAM: if (xfer) begin
                    if (slice_idx == last_slice) begin
                        bus.dout_valid <= 1'b0;
                        if (bus.rd_addr == last_addr) begin
                            state <= DONE;
                            transfer_done <= 1'b1;
                        end else begin
                            bus.rd_addr <= bus.rd_addr + 1'b1;
                            lat <= 2'(ram_latency);
                            state <= FETCH;
                        end
                    end else begin
                        slice_idx <= slice_idx + 1'b1;
                        bus.dout <= next_slice;
                    end
                end
                DONE: begin
                    transfer_done <= 1'b0;
                    busy <= 1'b0;
                    bus.rd_addr <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_UNLOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) checksum <= '0;
        else if (state == IDLE && start_signal) checksum <= '0;
        else if (state == STREAM && xfer) checksum <= checksum ^ bus.dout;
    end
`endif
endmodule

// File: tb/tb_mem_burst_unloader.sv
// tb_mem_burst_unloader: directed checks of readback order, backpressure, abort and checksum
module tb_mem_burst_unloader;
    import mem_burst_unloader_pkg::*;
    localparam int W = slice_width(8, 3);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_signal = 1'b0;
    logic busy, transfer_done;
    logic [W-1:0] mem [4][8];
    int checks = 0;
    int errors = 0;
`ifdef MEM_UNLOAD_CHECKSUM_EN
    logic [W-1:0] checksum;
`endif

    mem_burst_unloader_if #(.W(W), .address_width(2), .burst_index(8)) bus();

    mem_burst_unloader #(
        .no_of_digits(8), .radix_bits(3), .address_width(2),
        .max_ram_address(4), .burst_index(8), .ram_latency(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_signal(start_signal),
        .bus(bus.master),
        .busy(busy),
        .transfer_done(transfer_done)
`ifdef MEM_UNLOAD_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // one-cycle registered RAM read
    always @(posedge clk)
        for (int k = 0; k < 8; k++) bus.ram_q[k*W +: W] <= mem[bus.rd_addr][k];

    task automatic fill(input int mode);
        for (int a = 0; a < 4; a++)
            for (int k = 0; k < 8; k++)
                mem[a][k] = mode == 0 ? W'(a * 8 + k) : ((a == 1 && k == 2) ? W'('h5A) : '0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start_signal = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (transfer_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", transfer_done); end
        checks++; if (bus.rd_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.rd_addr); end
        reset = 1'b1;
    endtask

    task automatic test_first_word;
        int n;
        @(negedge clk);
        start_signal = 1'b1;
        bus.dout_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_signal = 1'b0;
            checks++; if (bus.dout_valid !== (c >= 3)) begin errors++; $display("FAIL first_valid cyc %0d got %b want %b", c, bus.dout_valid, c >= 3); end
            if (c >= 3) begin
                checks++; if (bus.dout !== W'(c - 3)) begin errors++; $display("FAIL first_dout cyc %0d got %0d want %0d", c, bus.dout, c - 3); end
            end
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_idle busy got %b want 0", busy); end
    endtask

    task automatic run_sweep(input bit stall);
        int exp, cyc, hold;
        logic pv, pr;
        logic [W-1:0] pd, acc;
        bit done_seen;
        exp = 0; cyc = 0; hold = 0; pv = 0; pr = 0; pd = '0; acc = '0; done_seen = 0;
        @(negedge clk);
        start_signal = 1'b1;
        bus.dout_ready = 1'b1;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_signal = 1'b0;
            if (transfer_done) begin
                done_seen = 1;
                checks++; if (exp != 32) begin errors++; $display("FAIL sweep_count got %0d want 32", exp); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_done_busy got %b want 1", busy); end
                checks++; if (bus.rd_addr !== 2'd3) begin errors++; $display("FAIL sweep_last_addr got %0d want 3", bus.rd_addr); end
                if (!stall) begin
                    checks++; if (cyc != 41) begin errors++; $display("FAIL sweep_cycles got %0d want 41", cyc); end
                end
`ifdef MEM_UNLOAD_CHECKSUM_EN
                checks++; if (checksum !== acc) begin errors++; $display("FAIL sweep_checksum got %h want %h", checksum, acc); end
`endif
            end else begin
                if (pv && !pr) begin
                    checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== pd) begin errors++; $display("FAIL hold got v=%b d=%0d want v=1 d=%0d", bus.dout_valid, bus.dout, pd); end
                end
                if (bus.dout_valid) begin
                    checks++; if (exp > 31 || bus.dout !== mem[exp/8][exp%8]) begin errors++; $display("FAIL sweep_dout idx %0d got %0d", exp, bus.dout); end
                    checks++; if (bus.rd_addr !== 2'(exp / 8)) begin errors++; $display("FAIL sweep_addr idx %0d got %0d want %0d", exp, bus.rd_addr, exp / 8); end
                end
                bus.dout_ready = !stall || ((exp != 3 || hold >= 2) && (cyc % 7 != 4));
                if (exp == 3 && !bus.dout_ready && bus.dout_valid) hold++;
                pv = bus.dout_valid; pr = bus.dout_ready; pd = bus.dout;
                if (bus.dout_valid && bus.dout_ready) begin
                    acc ^= bus.dout;
                    exp++;
                end
            end
        end
        checks++; if (!done_seen) begin errors++; $display("FAIL sweep_timeout exp %0d", exp); end
        @(negedge clk);
        checks++; if (transfer_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", transfer_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_busy got %b want 0", busy); end
        checks++; if (bus.rd_addr !== 2'd0) begin errors++; $display("FAIL post_addr got %0d want 0", bus.rd_addr); end
    endtask

    task automatic test_full_sweep;
        run_sweep(1'b0);
    endtask

    task automatic test_backpressure;
        run_sweep(1'b1);
    endtask

    task automatic test_abort;
        int exp;
        bit hit;
        exp = 0; hit = 0;
        @(negedge clk);
        start_signal = 1'b1;
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            start_signal = 1'b0;
            if (bus.dout_valid) begin
                checks++; if (bus.dout !== W'(exp)) begin errors++; $display("FAIL abort_dout got %0d want %0d", bus.dout, exp); end
                if (exp == 10) start_signal = 1'b1;
                if (exp == 21) hit = 1;
                else exp++;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_timeout exp %0d", exp); end
        reset = 1'b0;
        #1;
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL abort_dout0 got %0d want 0", bus.dout); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (transfer_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", transfer_done); end
        checks++; if (bus.rd_addr !== 2'd0) begin errors++; $display("FAIL abort_addr got %0d want 0", bus.rd_addr); end
`ifdef MEM_UNLOAD_CHECKSUM_EN
        checks++; if (checksum !== '0) begin errors++; $display("FAIL abort_checksum got %h want 0", checksum); end
`endif
        @(negedge clk);
        reset = 1'b1;
        run_sweep(1'b0);
    endtask

`ifdef MEM_UNLOAD_CHECKSUM_EN
    task automatic test_checksum;
        fill(1);
        run_sweep(1'b0);
        checks++; if (checksum !== W'('h5A)) begin errors++; $display("FAIL checksum_single got %h want 5a", checksum); end
        fill(0);
        run_sweep(1'b0);
        checks++; if (checksum !== '0) begin errors++; $display("FAIL checksum_sweep got %h want 0", checksum); end
    endtask
`endif

    initial begin
        fill(0);
        test_reset;
        test_first_word;
        test_full_sweep;
        test_backpressure;
        test_abort;
`ifdef MEM_UNLOAD_CHECKSUM_EN
        test_checksum;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_burst_unloader.md
Name: mem_burst_unloader

Overview:
- Downstream readback stage for the on-chip capture RAM.
- After capture, walks every RAM address and splits each wide burst word into burst_index digit-vectors.
- Streams the vectors out one per handshake over valid/ready to the transfer path, then signals transfer_done.
- Sits between the RAM read port and the host transfer logic; driven by the same slow burst clock as the RAM.

Parameters:
- no_of_digits, 8, digits per operand; output slice carries no_of_digits+1 digits
- radix_bits, 3, bits per signed digit
- address_width, 14, RAM address width
- max_ram_address, 1024, number of RAM words read; 1 <= max_ram_address <= 2^address_width
- burst_index, 8, slices per RAM word
- ram_latency, 1, cycles from rd_addr change to valid ram_q; allowed range 1..3

Ports:
- clk, in, 1, burst-rate clock (same clock as the RAM)
- reset, in, 1, asynchronous, active-low
- start_signal, in, 1, begin readback; sampled only in IDLE
- rd_addr, out, address_width, RAM read address
- ram_q, in, (no_of_digits+1)*radix_bits*burst_index, RAM read data
- dout, out, (no_of_digits+1)*radix_bits, current slice
- dout_valid, out, 1, dout holds a valid slice
- dout_ready, in, 1, consumer accepts the slice
- busy, out, 1, high in every state except IDLE
- transfer_done, out, 1, one-cycle pulse after the final slice is accepted

Behaviour:
- Derived widths: W = (no_of_digits+1)*radix_bits; slice k = ram_q[(k+1)*W-1 : k*W].
- Reset (reset=0, asynchronous):
  - state=IDLE, rd_addr=0, slice counter=0, buffer=0
  - dout=0, dout_valid=0, busy=0, transfer_done=0
- Reset asserted mid-operation aborts immediately. No pulse is emitted, and partial progress is discarded.
- IDLE:
  - rd_addr=0.
  - start_signal=1 -> FETCH with latency counter=ram_latency.
  - start_signal held high keeps restarting only after a return to IDLE; it is level-sampled.
- FETCH:
  - Counter decrements each cycle. At 0 -> LOAD.
  - rd_addr is held constant throughout FETCH.
- LOAD:
  - Captures ram_q into the burst buffer, sets slice=0, goes to STREAM.
  - dout_valid=0 in FETCH and LOAD.
- STREAM:
  - dout = buffer slice[slice], registered; dout_valid=1.
  - Transfer happens when dout_valid & dout_ready. The slice index advances on the next cycle.
  - With dout_ready=0, dout and dout_valid are held stable. Valid is never withdrawn without a transfer.
  - Transfer on slice burst_index-1 with rd_addr < max_ram_address-1: rd_addr+1, then FETCH.
  - Transfer on slice burst_index-1 with rd_addr == max_ram_address-1: go to DONE. The compare is against max-1, so there is no counter overflow when max_ram_address = 2^address_width.
- DONE:
  - transfer_done=1 for exactly one cycle, busy=1, then IDLE.
- start_signal outside IDLE is ignored.
- Throughput: worst case burst_index + ram_latency + 1 cycles per RAM word when dout_ready is held high.
- Total accepted slices = max_ram_address*burst_index. Order: address ascending, slice ascending.

Optional Feature:
- Macro: MEM_UNLOAD_CHECKSUM_EN.
- When defined:
  - Adds output checksum, width W.
  - On each transfer, checksum <= checksum XOR dout.
  - Cleared to 0 on reset and on leaving IDLE.
  - Value is stable from the transfer_done pulse until the next start.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (the memory-test package used by the RAM/address/control blocks) holds:
  - state encoding constants IDLE=0, FETCH=1, LOAD=2, STREAM=3, DONE=4
  - the W width function
- One sub-module: burst_slice_mux. It is a combinational selector with inputs buffer and slice index and output W-bit slice, instantiated inside the registered dout path.

Test Plan:
- Reset value check: with reset held low, all outputs are 0. Release, then pulse start with RAM word 0 slices = 0..7 and dout_ready=1. Required: dout_valid rises 3 cycles after start (FETCH 1 + LOAD 1 + register), and dout = 0,1,...,7 on consecutive cycles.
- Backpressure: toggle dout_ready 1,0,0,1 during slice 3. Required: dout stays 3 while not accepted, and each slice is accepted exactly once.
- Full sweep: max_ram_address=4, burst_index=8, RAM filled with address*8+slice. Required: 32 transfers with values 0..31 in order, transfer_done exactly 1 cycle after transfer 31, then busy=0.
- Boundary: address_width=2, max_ram_address=4. Required: rd_addr ends at 3 with no wrap to 0 before DONE.
- Mid-operation events: start_signal pulsed in STREAM is ignored. reset dropped at slice 5 of address 2 sends all outputs to 0 asynchronously. A new start restarts at address 0, slice 0.
- MEM_UNLOAD_CHECKSUM_EN: with 32 slices of values 0..31, checksum = 0 at transfer_done (XOR of 0..31). With a single nonzero slice 0x5A, checksum = 0x5A.
